// File: rtl/wb_pkg.sv
// Shared Wishbone responder types: FSM state enum, bus widths, byte-lane mask helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package wb_pkg;

  localparam int WB_DW   = 32;
  localparam int WB_AW   = 32;
  localparam int WB_SELW = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } wb_resp_state_t;

  // Expand the 4-bit byte-lane select into a 32-bit bit mask.
  function automatic logic [WB_DW-1:0] wb_sel_mask(input logic [WB_SELW-1:0] sel);
    logic [WB_DW-1:0] m;
    m = '0;
    for (int i = 0; i < WB_SELW; i++) begin
      m[8*i +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_resp_mem.sv
// Single-port word RAM with per-byte write mask and asynchronous read.
// Latency: read is combinational; a write lands at the clock edge.
// Backpressure: none; always accepts a write when i_we is high.
module wb_resp_mem
  import wb_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic                    clk_i,
  input  logic                    i_we,
  input  logic [$clog2(SIZE)-1:0] i_addr,
  input  logic [WB_DW-1:0]        i_wdat,
  input  logic [WB_DW-1:0]        i_mask,
  output logic [WB_DW-1:0]        o_rdat
);

  logic [WB_DW-1:0] r_mem [SIZE];

  // Merge only the masked bits of the write data into the addressed word.
  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_mem[i_addr] <= (r_mem[i_addr] & ~i_mask) | (i_wdat & i_mask);
    end
  end

  assign o_rdat = r_mem[i_addr];

endmodule

// File: rtl/wb_ram_responder.sv
// Wishbone classic slave: address-window decode, scratchpad RAM, programmable wait states, ack/err.
// Latency: ack/err is high for one cycle, 1+WAIT_STATES cycles after the request is sampled.
// Backpressure: classic handshake only; one transfer per 2+WAIT_STATES cycles, dropping cyc aborts while waiting.
module wb_ram_responder
  import wb_pkg::*;
#(
  parameter int          SIZE        = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WB_DW-1:0]   wb_dat_i,
  input  logic [WB_AW-1:0]   wb_adr_i,
  input  logic [WB_SELW-1:0] wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  output logic [WB_DW-1:0]   wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o
);

  localparam int             IW        = $clog2(SIZE);
  localparam logic [WB_AW-1:0] WIN_BYTES = WB_AW'(SIZE * 4);

  wb_resp_state_t     r_state;
  logic [3:0]         r_cnt;
  logic               r_we;
  logic               r_valid;
  logic [WB_SELW-1:0] r_sel;
  logic [WB_DW-1:0]   r_dat;
  logic [IW-1:0]      r_idx;

  logic [WB_AW-1:0]   w_offset;
  logic               w_valid;
  logic               w_req;
  logic [IW-1:0]      w_idx;
  logic [IW-1:0]      w_mem_idx;
  logic               w_mem_we;
  logic [WB_DW-1:0]   w_rdat;
  logic               w_rsp_valid;
  logic               w_rsp_we;
  logic [WB_SELW-1:0] w_rsp_sel;
  logic [WB_DW-1:0]   w_rsp_dat;

  // Window decode: wrapped offset from the base, must be in range and word aligned.
  assign w_offset = wb_adr_i - BASE_ADDR;
  assign w_valid  = (w_offset < WIN_BYTES) && (wb_adr_i[1:0] == 2'b00);
  assign w_idx    = w_offset[IW+1:2];
  assign w_req    = wb_cyc_i & wb_stb_i;

  // With zero wait states the response is formed straight from the bus in IDLE;
  // otherwise it comes from the captured request.
  assign w_rsp_valid = (r_state == IDLE) ? w_valid  : r_valid;
  assign w_rsp_we    = (r_state == IDLE) ? wb_we_i  : r_we;
  assign w_rsp_sel   = (r_state == IDLE) ? wb_sel_i : r_sel;
  assign w_mem_idx   = (r_state == IDLE) ? w_idx    : r_idx;
  assign w_rsp_dat   = (w_rsp_valid && !w_rsp_we) ? (w_rdat & wb_sel_mask(w_rsp_sel)) : '0;

  // The write commits at the end of RESP, so an abort or reset earlier never touches memory.
  assign w_mem_we = (r_state == RESP) && r_we && r_valid && !rst_i;

  wb_resp_mem #(
    .SIZE(SIZE)
  ) u_mem (
    .clk_i  (clk_i),
    .i_we   (w_mem_we),
    .i_addr (w_mem_idx),
    .i_wdat (r_dat),
    .i_mask (wb_sel_mask(r_sel)),
    .o_rdat (w_rdat)
  );

  // Request FSM: capture in IDLE, count wait states, drive one registered response cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_we    <= wb_we_i;
            r_sel   <= wb_sel_i;
            r_dat   <= wb_dat_i;
            r_idx   <= w_idx;
            r_valid <= w_valid;
            if (WAIT_STATES > 0) begin
              r_state <= WAIT;
              r_cnt   <= 4'(WAIT_STATES - 1);
            end else begin
              r_state  <= RESP;
              wb_ack_o <= w_valid;
              wb_err_o <= !w_valid;
              wb_dat_o <= w_rsp_dat;
            end
          end
        end
        WAIT: begin
          if (!wb_cyc_i) begin
            r_state <= IDLE;
          end else if (r_cnt == 4'd0) begin
            r_state  <= RESP;
            wb_ack_o <= r_valid;
            wb_err_o <= !r_valid;
            wb_dat_o <= w_rsp_dat;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
